wd_supervisor: RTL and testbench
================================

# wd_supervisor

Sequencer for the `watchdog_timer` in the AM radio FPGA.
- Gathers liveness pulses from several client tasks (SCPI handler, DSP chain, network stack, etc.) and emits one consolidated heartbeat only when every enabled client has checked in within a round.
- Arms the watchdog after a start-up delay.
- On watchdog expiry, mutes the RF output, waits out a recovery interval and then clears the watchdog with `force_reset`.
- Sits between the control/software domain and `watchdog_timer`, and drives the RF mute gate.

## Interface
Parameters:
- `N_CLIENTS`, 4: number of heartbeat clients (1–16).
- `ROUND_CYCLES`, 1000: length of one check-in round in clk cycles (≥ 2).
- `ARM_DELAY`, 16: cycles spent in ARMING before the watchdog is enabled (≥ 1).
- `RECOVER_CYCLES`, 64: cycles spent in FAULT before `force_reset` is issued (≥ 1).

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `client_alive` in N_CLIENTS: single-cycle alive pulses, one bit per client.
- `client_mask` in N_CLIENTS: 1 = client must check in; latched at each round start.
- `sys_enable` in 1: software enable for the supervision function.
- `wd_triggered` in 1: `triggered` output of `watchdog_timer`.
- `wd_heartbeat` out 1: heartbeat to `watchdog_timer`; a single-cycle pulse.
- `wd_enable` out 1: enable to `watchdog_timer`.
- `wd_force_reset` out 1: force-reset to `watchdog_timer`; a single-cycle pulse.
- `rf_mute` out 1: 1 = RF output gated off.
- `state` out 2: FSM state code.
- `missed_mask` out N_CLIENTS: clients absent in the most recent incomplete round.
- `fault_count` out 8: count of watchdog faults; saturates at 255.

## Operation
- All outputs are registered. Reset value of every output is 0, and `state` resets to IDLE.
- State codes: IDLE=0, ARMING=1, RUN=2, FAULT=3.

IDLE:
- `wd_enable`=0.
- When `sys_enable`=1, go to ARMING and load the arm counter.

ARMING:
- `wd_enable`=0.
- After exactly `ARM_DELAY` cycles, go to RUN and start a round.
- If `sys_enable`=0, go to IDLE immediately.

Round start:
- round counter := 0, seen := 0, latched_mask := `client_mask`.
- RUN is entered with round counter = 0.

RUN:
- `wd_enable`=1.
- Every cycle: seen_next = seen | (`client_alive` & latched_mask).
- **Complete:** if seen_next == latched_mask and latched_mask ≠ 0, pulse `wd_heartbeat` on the next cycle and start a new round.
- **Timeout:** if the round counter reaches `ROUND_CYCLES`-1 without completion:
  - with latched_mask ≠ 0: `missed_mask` := latched_mask & ~seen_next, no heartbeat, start a new round;
  - with latched_mask = 0: issue a heartbeat at timeout instead, leaving `missed_mask` unchanged.
- A completed round leaves `missed_mask` unchanged.
- Alive bits from unmasked clients are ignored. Repeated pulses from one client within a round are harmless.
- Priority, highest first:
  1. `wd_triggered`=1 → FAULT, `rf_mute` := 1, `fault_count` += 1 (saturating).
  2. `sys_enable`=0 → IDLE.
  3. Round logic.

FAULT:
- `rf_mute`=1 and `wd_enable`=1 are held. `sys_enable` and `client_alive` are ignored.
- After `RECOVER_CYCLES` cycles, pulse `wd_force_reset` for one cycle.
- Then go to ARMING if `sys_enable`=1, otherwise to IDLE.

`rf_mute`:
- Set only on entry to FAULT.
- Cleared only on entry to RUN, or by `rst`.
- It therefore remains 1 in IDLE and ARMING after a fault.

Reset:
- Asserting `rst` at any point, including mid-round or mid-FAULT, immediately clears all state and outputs.
- No `force_reset` is issued on reset.

## Timing
- The alive pulse that completes a round at cycle t gives `wd_heartbeat`=1 at t+1 only.
- At t+1 the new round begins: counter=0 and `client_mask` is re-latched.
- `sys_enable` rising at t: `state`=ARMING at t+1, RUN at t+1+`ARM_DELAY`, `wd_enable`=1 from that same cycle.
- `wd_triggered` at t: `state`=FAULT and `rf_mute`=1 at t+1.
  - `wd_force_reset`=1 at t+`RECOVER_CYCLES`+1.
  - `state`=ARMING/IDLE at t+`RECOVER_CYCLES`+2.
- A completing alive pulse in the same cycle as `wd_triggered`: the fault wins and no heartbeat is issued.
- A completing alive pulse on the timeout cycle: this counts as completion, so a heartbeat is issued and `missed_mask` is not updated.
- `wd_heartbeat` and `wd_force_reset` are never high in the same cycle.

## Structure
- Package `wd_supervisor_pkg`:
  - state enum with the 2-bit codes above;
  - `FAULT_CNT_W` = 8.
- Counter widths are `$clog2` of the relevant parameter.
- Sub-module `wd_round_tracker` (N_CLIENTS, ROUND_CYCLES):
  - holds latched_mask, seen and the round counter;
  - outputs `complete`, `timeout` and `missed`;
  - takes `start` and `clear` inputs.
- The top level holds the FSM, the arm/recovery counter, `rf_mute` and `fault_count`.

## Test plan
1. **Reset and arming:** `rst` pulse, then `sys_enable`=1 with `ARM_DELAY`=16.
   - All outputs 0 during reset.
   - `state`=1 for 16 cycles, then `state`=2 and `wd_enable`=1.
2. **Full check-in:** mask=4'b1011, alive pulses on bits 0, 1, 3 in separate cycles.
   - One `wd_heartbeat` pulse, one cycle after the bit-3 pulse.
   - Bit-2 pulses have no effect.
3. **Missed client:** mask=4'b0011, only bit 0 pulses for `ROUND_CYCLES`.
   - No heartbeat.
   - `missed_mask`=4'b0010 after the timeout cycle.
4. **Fault recovery:** `wd_triggered`=1 in RUN with `RECOVER_CYCLES`=64.
   - `rf_mute`=1 and `fault_count`=1.
   - `wd_force_reset` pulses exactly at +65.
   - Then ARMING, then RUN with `rf_mute`=0.
5. **Simultaneous events:** the completing alive pulse coincides with `wd_triggered` → FAULT, no heartbeat. Separately, 256 faults → `fault_count` stays at 255.
6. **Disable/reset mid-operation:** `sys_enable`=0 mid-round → IDLE and `wd_enable`=0 next cycle. `rst` in FAULT → everything 0 and no `wd_force_reset` pulse.

Source files
------------

// File: rtl/wd_supervisor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wd_supervisor_pkg
// Brief    : Shared state encoding and widths for the watchdog supervisor.
// Revision : 1.0 - initial release
// ============================================================================
package wd_supervisor_pkg;

  // Supervisor FSM states; codes are visible on the state output
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } wd_state_e;

  localparam int FAULT_CNT_W = 8;

endpackage : wd_supervisor_pkg
`default_nettype wire

// File: rtl/wd_round_tracker.sv
`default_nettype none
// ============================================================================
// Module   : wd_round_tracker
// Brief    : Tracks one client check-in round: latched mask, seen set and
//            round age. Reports completion, timeout and missing clients.
// Revision : 1.0 - initial release
// ============================================================================
module wd_round_tracker #(
  parameter int N_CLIENTS    = 4,
  parameter int ROUND_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic [N_CLIENTS-1:0] alive_i,
  input  logic [N_CLIENTS-1:0] mask_i,
  output logic                 complete_o,
  output logic                 timeout_o,
  output logic                 empty_o,
  output logic [N_CLIENTS-1:0] missed_o
);

  localparam int RND_W = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [RND_W-1:0] C_LAST = RND_W'(ROUND_CYCLES - 1);

  logic [N_CLIENTS-1:0] latched_q;
  logic [N_CLIENTS-1:0] seen_q;
  logic [N_CLIENTS-1:0] seen_d;
  logic [RND_W-1:0]     cnt_q;
  logic [RND_W-1:0]     cnt_d;

  // Accumulate check-ins from required clients only; report round status
  always_comb begin
    seen_d     = seen_q | (alive_i & latched_q);
    cnt_d      = cnt_q + RND_W'(1);
    empty_o    = (latched_q == '0);
    complete_o = !empty_o && (seen_d == latched_q);
    timeout_o  = (cnt_q == C_LAST);
    missed_o   = latched_q & ~seen_d;
  end

  // Round registers: start reloads, clear idles, otherwise the round ages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latched_q <= '0;
      seen_q    <= '0;
      cnt_q     <= '0;
    end else if (start_i) begin
      latched_q <= mask_i;
      seen_q    <= '0;
      cnt_q     <= '0;
    end else if (clear_i) begin
      latched_q <= '0;
      seen_q    <= '0;
      cnt_q     <= '0;
    end else begin
      seen_q    <= seen_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule : wd_round_tracker
`default_nettype wire

// File: rtl/wd_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : wd_supervisor
// Brief    : Consolidates client heartbeats for watchdog_timer, arms it after
//            a start-up delay and runs the mute/recover/force-reset sequence
//            on expiry.
// Revision : 1.0 - initial release
// ============================================================================
module wd_supervisor
  import wd_supervisor_pkg::*;
#(
  parameter int N_CLIENTS      = 4,
  parameter int ROUND_CYCLES   = 1000,
  parameter int ARM_DELAY      = 16,
  parameter int RECOVER_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CLIENTS-1:0]   client_alive_i,
  input  logic [N_CLIENTS-1:0]   client_mask_i,
  input  logic                   sys_enable_i,
  input  logic                   wd_triggered_i,
  output logic                   wd_heartbeat_o,
  output logic                   wd_enable_o,
  output logic                   wd_force_reset_o,
  output logic                   rf_mute_o,
  output logic [1:0]             state_o,
  output logic [N_CLIENTS-1:0]   missed_mask_o,
  output logic [FAULT_CNT_W-1:0] fault_count_o
);

  // One down-counter serves both ARMING and FAULT, so size it for the larger
  localparam int C_CNT_MAX = (ARM_DELAY > RECOVER_CYCLES) ? ARM_DELAY : RECOVER_CYCLES;
  localparam int CNT_W     = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] C_ARM_LOAD = CNT_W'(ARM_DELAY - 1);
  localparam logic [CNT_W-1:0] C_REC_LOAD = CNT_W'(RECOVER_CYCLES - 1);

  wd_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  hb_q, hb_d;
  logic                  fr_q, fr_d;
  logic                  en_q, en_d;
  logic                  mute_q, mute_d;
  logic [FAULT_CNT_W-1:0] fc_q, fc_d;
  logic [N_CLIENTS-1:0]  missed_q, missed_d;

  logic                  rt_start;
  logic                  rt_clear;
  logic                  rt_complete;
  logic                  rt_timeout;
  logic                  rt_empty;
  logic [N_CLIENTS-1:0]  rt_missed;

  // The tracker only ages while in RUN; any other state holds it idle
  assign rt_clear = (state_q != ST_RUN);

  wd_round_tracker #(
    .N_CLIENTS    (N_CLIENTS),
    .ROUND_CYCLES (ROUND_CYCLES)
  ) u_round_tracker (
    .clk        (clk),
    .rst        (rst),
    .start_i    (rt_start),
    .clear_i    (rt_clear),
    .alive_i    (client_alive_i),
    .mask_i     (client_mask_i),
    .complete_o (rt_complete),
    .timeout_o  (rt_timeout),
    .empty_o    (rt_empty),
    .missed_o   (rt_missed)
  );

  // Next-state and next-output logic; pulses default low every cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hb_d     = 1'b0;
    fr_d     = 1'b0;
    mute_d   = mute_q;
    fc_d     = fc_q;
    missed_d = missed_q;
    rt_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sys_enable_i) begin
          state_d = ST_ARMING;
          cnt_d   = C_ARM_LOAD;
        end
      end
      ST_ARMING: begin
        if (!sys_enable_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d  = ST_RUN;
          mute_d   = 1'b0;
          rt_start = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (wd_triggered_i) begin
          state_d = ST_FAULT;
          mute_d  = 1'b1;
          cnt_d   = C_REC_LOAD;
          if (fc_q != '1) fc_d = fc_q + FAULT_CNT_W'(1);
        end else if (!sys_enable_i) begin
          state_d = ST_IDLE;
        end else if (rt_complete) begin
          hb_d     = 1'b1;
          rt_start = 1'b1;
        end else if (rt_timeout) begin
          // An empty mask has nobody to wait for, so the timeout stands in
          if (rt_empty) hb_d = 1'b1;
          else          missed_d = rt_missed;
          rt_start = 1'b1;
        end
      end
      ST_FAULT: begin
        // The force-reset pulse marks the last FAULT cycle
        if (fr_q) begin
          state_d = sys_enable_i ? ST_ARMING : ST_IDLE;
          cnt_d   = C_ARM_LOAD;
        end else if (cnt_q == '0) begin
          fr_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    en_d = (state_d == ST_RUN) || (state_d == ST_FAULT);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hb_q     <= 1'b0;
      fr_q     <= 1'b0;
      en_q     <= 1'b0;
      mute_q   <= 1'b0;
      fc_q     <= '0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hb_q     <= hb_d;
      fr_q     <= fr_d;
      en_q     <= en_d;
      mute_q   <= mute_d;
      fc_q     <= fc_d;
      missed_q <= missed_d;
    end
  end

  assign wd_heartbeat_o   = hb_q;
  assign wd_force_reset_o = fr_q;
  assign wd_enable_o      = en_q;
  assign rf_mute_o        = mute_q;
  assign state_o          = state_q;
  assign missed_mask_o    = missed_q;
  assign fault_count_o    = fc_q;

endmodule : wd_supervisor
`default_nettype wire

// File: tb/tb_wd_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_wd_supervisor
// Brief    : Self-checking bench for wd_supervisor against a timestamp-based
//            behavioural model, directed scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wd_supervisor;

  localparam int N   = 4;
  localparam int RC  = 40;
  localparam int AD  = 16;
  localparam int RCV = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] alive, mask;
  logic         en, trig;
  logic         hb, wden, fr, mute;
  logic [1:0]   st;
  logic [N-1:0] missed;
  logic [7:0]   fc;

  always #5 clk = ~clk;

  wd_supervisor #(
    .N_CLIENTS(N), .ROUND_CYCLES(RC), .ARM_DELAY(AD), .RECOVER_CYCLES(RCV)
  ) dut (
    .clk(clk), .rst(rst),
    .client_alive_i(alive), .client_mask_i(mask),
    .sys_enable_i(en), .wd_triggered_i(trig),
    .wd_heartbeat_o(hb), .wd_enable_o(wden), .wd_force_reset_o(fr),
    .rf_mute_o(mute), .state_o(st), .missed_mask_o(missed), .fault_count_o(fc)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: events are scheduled by absolute cycle number
  int         m_st, m_fc, m_age, m_cyc, m_run_at, m_fr_at;
  logic       m_hb, m_fr, m_en, m_mute;
  logic [N-1:0] m_missed, m_seen, m_latched;

  task automatic model_reset();
    m_st = 0; m_fc = 0; m_age = 0; m_run_at = 0; m_fr_at = 0;
    m_hb = 0; m_fr = 0; m_en = 0; m_mute = 0;
    m_missed = '0; m_seen = '0; m_latched = '0;
  endtask

  task automatic new_round(input logic [N-1:0] mk);
    m_age = 0; m_seen = '0; m_latched = mk;
  endtask

  task automatic model_next(input logic [N-1:0] a, input logic [N-1:0] mk,
                            input logic e, input logic tr);
    int ns;
    logic [N-1:0] s;
    ns = m_st; m_hb = 0; m_fr = 0;
    case (m_st)
      0: if (e) begin ns = 1; m_run_at = m_cyc + 1 + AD; end
      1: if (!e) ns = 0;
         else if (m_cyc + 1 == m_run_at) begin ns = 2; m_mute = 0; new_round(mk); end
      2: if (tr) begin
           ns = 3; m_mute = 1; if (m_fc < 255) m_fc++; m_fr_at = m_cyc + RCV + 1;
         end else if (!e) ns = 0;
         else begin
           s = m_seen | (a & m_latched);
           if (m_latched != 0 && s == m_latched) begin m_hb = 1; new_round(mk); end
           else if (m_age == RC - 1) begin
             if (m_latched == 0) m_hb = 1; else m_missed = m_latched & ~s;
             new_round(mk);
           end else begin m_seen = s; m_age++; end
         end
      default: begin
        if (m_cyc + 1 == m_fr_at) m_fr = 1;
        if (m_cyc == m_fr_at) begin ns = e ? 1 : 0; m_run_at = m_cyc + 1 + AD; end
      end
    endcase
    m_st = ns;
    m_en = (ns == 2) || (ns == 3);
  endtask

  task automatic compare_all();
    check("state", 32'(st), 32'(m_st));
    check("wd_heartbeat", 32'(hb), 32'(m_hb));
    check("wd_force_reset", 32'(fr), 32'(m_fr));
    check("wd_enable", 32'(wden), 32'(m_en));
    check("rf_mute", 32'(mute), 32'(m_mute));
    check("fault_count", 32'(fc), 32'(m_fc));
    check("missed_mask", 32'(missed), 32'(m_missed));
  endtask

  task automatic step(input logic [N-1:0] a, input logic [N-1:0] mk,
                      input logic e, input logic tr);
    alive = a; mask = mk; en = e; trig = tr;
    model_next(a, mk, e, tr);
    @(posedge clk); #1;
    m_cyc++;
    compare_all();
  endtask

  task automatic wait_run(input logic [N-1:0] mk);
    int k;
    k = 0;
    while (m_st != 2 && k < 200) begin step('0, mk, 1'b1, 1'b0); k++; end
    check("reach_run", 32'(k < 200), 32'd1);
  endtask

  initial begin
    #10000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hb_cnt;
    rst = 1'b1; alive = '0; mask = 4'b1011; en = 1'b0; trig = 1'b0;
    m_cyc = 0; model_reset();
    // 1. reset and arming
    repeat (3) begin @(posedge clk); #1; compare_all(); end
    rst = 1'b0;
    repeat (3) step('0, 4'b1011, 1'b0, 1'b0);
    step('0, 4'b1011, 1'b1, 1'b0);
    check("arming_entry", 32'(st), 32'd1);
    repeat (AD - 1) step('0, 4'b1011, 1'b1, 1'b0);
    check("still_arming", 32'(st), 32'd1);
    step('0, 4'b1011, 1'b1, 1'b0);
    check("run_entry", 32'(st), 32'd2);
    check("run_wd_enable", 32'(wden), 32'd1);

    // 2. full check-in, bit 2 is unmasked
    step(4'b0100, 4'b1011, 1'b1, 1'b0);
    step(4'b0001, 4'b1011, 1'b1, 1'b0);
    step(4'b0100, 4'b1011, 1'b1, 1'b0);
    step(4'b0010, 4'b1011, 1'b1, 1'b0);
    check("no_hb_before_bit3", 32'(hb), 32'd0);
    step(4'b1000, 4'b1011, 1'b1, 1'b0);
    check("hb_after_bit3", 32'(hb), 32'd1);
    step('0, 4'b1011, 1'b1, 1'b0);
    check("hb_single_cycle", 32'(hb), 32'd0);

    // 3. missed client: only bit 0 checks in
    hb_cnt = 0;
    for (int k = 0; k < 2 * RC + 2; k++) begin
      step((k % 3 == 0) ? 4'b0001 : 4'b0000, 4'b0011, 1'b1, 1'b0);
      if (hb) hb_cnt++;
    end
    check("missed_no_hb", 32'(hb_cnt), 32'd0);
    check("missed_mask_0010", 32'(missed), 32'b0010);

    // 4. fault recovery
    step('0, 4'b0011, 1'b1, 1'b1);
    check("fault_state", 32'(st), 32'd3);
    check("fault_mute", 32'(mute), 32'd1);
    check("fault_count_1", 32'(fc), 32'd1);
    for (int k = 1; k <= RCV; k++) begin
      step('0, 4'b0011, 1'b1, 1'b0);
      check("force_reset_timing", 32'(fr), 32'(k == RCV));
    end
    step('0, 4'b0011, 1'b1, 1'b0);
    check("post_fault_arming", 32'(st), 32'd1);
    check("mute_held_arming", 32'(mute), 32'd1);
    repeat (AD) step('0, 4'b0011, 1'b1, 1'b0);
    check("rerun_state", 32'(st), 32'd2);
    check("rerun_unmuted", 32'(mute), 32'd0);

    // 5. completion coincident with trigger, then saturation
    for (int k = 0; k < RC + 2; k++) step('0, 4'b0001, 1'b1, 1'b0);
    step(4'b0001, 4'b0001, 1'b1, 1'b1);
    check("coincident_no_hb", 32'(hb), 32'd0);
    check("coincident_fault", 32'(st), 32'd3);
    for (int f = 0; f < 256; f++) begin
      wait_run(4'b0001);
      step('0, 4'b0001, 1'b1, 1'b1);
    end
    check("fault_count_sat", 32'(fc), 32'd255);

    // 6. disable mid-round, then reset mid-fault
    wait_run(4'b0011);
    repeat (5) step(4'b0001, 4'b0011, 1'b1, 1'b0);
    step('0, 4'b0011, 1'b0, 1'b0);
    check("disable_idle", 32'(st), 32'd0);
    check("disable_wd_enable", 32'(wden), 32'd0);
    wait_run(4'b0011);
    step('0, 4'b0011, 1'b1, 1'b1);
    repeat (10) step('0, 4'b0011, 1'b1, 1'b0);
    rst = 1'b1; #1;
    model_reset();
    compare_all();
    @(posedge clk); #1; compare_all();
    rst = 1'b0;
    repeat (RCV + 5) step('0, 4'b0011, 1'b0, 1'b0);

    // random traffic
    for (int k = 0; k < 4000; k++) begin
      logic [N-1:0] a;
      if ($urandom_range(0, 49) == 0) mask = 4'($urandom);
      a = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      step(a, mask, ($urandom_range(0, 299) != 0), ($urandom_range(0, 399) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_wd_supervisor
`default_nettype wire
